// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 single-bit select path between four requesters.
// Optional owner preemption after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic [3:0] data_in,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       data_out
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux4_rr_arbiter: MAX_HOLD must be in 2..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] grant_q, grant_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [2:0] pick_idle, pick_hand;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] CNT_MAX = 8'(MAX_HOLD - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    // Returns {found, index} of the first set bit scanning start, start+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        logic [1:0] win;
        found = 1'b0;
        win   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        pick_idle = rr_pick(req, ptr_q + 2'd1);
        // Owner bit masked so a handover never re-selects the current owner.
        pick_hand = rr_pick(req & ~grant_q, sel_q + 2'd1);

        if (state_q == IDLE) begin
            if (pick_idle[2]) begin
                state_d = GRANT;
                grant_d = 4'b0001 << pick_idle[1:0];
                sel_d   = pick_idle[1:0];
                ptr_d   = pick_idle[1:0];
`ifdef ARB_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end
        end else begin
            if (req[sel_q]) begin
`ifdef ARB_TIMEOUT_EN
                if (cnt_q == CNT_MAX && pick_hand[2]) begin
                    grant_d = 4'b0001 << pick_hand[1:0];
                    sel_d   = pick_hand[1:0];
                    ptr_d   = pick_hand[1:0];
                    cnt_d   = 8'd0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d   = cnt_q + 8'd1;
                end
`endif
            end else if (pick_hand[2]) begin
                grant_d = 4'b0001 << pick_hand[1:0];
                sel_d   = pick_hand[1:0];
                ptr_d   = pick_hand[1:0];
`ifdef ARB_TIMEOUT_EN
                cnt_d   = 8'd0;
`endif
            end else begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign grant    = grant_q;
    assign sel      = sel_q;
    assign busy     = (state_q == GRANT);
    assign data_out = busy ? data_in[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter; builds with or without ARB_TIMEOUT_EN (MAX_HOLD=4).
module tb_mux4_rr_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] data_in;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       data_out;

    int checks = 0;
    int failures = 0;

    mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
        .grant    (grant),
        .sel      (sel),
        .busy     (busy),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; outputs are read 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = 4'b0000;
        data_in = 4'b0000;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        req     = 4'b1111;
        data_in = 4'b0000;
        step();
        step();
        checks++;
        if (grant !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0 || data_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: grant=%b sel=%b busy=%b dout=%b, want 0000 00 0 0", grant, sel, busy, data_out);
        end
        reset = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0001 || sel !== 2'b00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant: grant=%b sel=%b busy=%b, want 0001 00 1", grant, sel, busy);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k <= 4; k++) begin
            exp = 4'b0001 << (k % 4);
            for (int h = 0; h < 3; h++) begin
                checks++;
                if (grant !== exp || busy !== 1'b1 || sel !== 2'(k % 4)) begin
                    failures++;
                    $display("FAIL fairness_k%0d_h%0d: grant=%b sel=%0d busy=%b, want %b %0d 1", k, h, grant, sel, busy, exp, k % 4);
                end
                if (k == 4) break;
                if (h < 2) step();
            end
            if (k < 4) begin
                req = 4'b1111 & ~exp;
                step();
                req = 4'b1111;
            end
        end
    endtask

    task automatic test_single_data();
        do_reset();
        req     = 4'b0100;
        data_in = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100 || sel !== 2'b10 || data_out !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: grant=%b sel=%b dout=%b, want 0100 10 1", grant, sel, data_out);
        end
        data_in = 4'b1011;
        #1;
        checks++;
        if (data_out !== 1'b0) begin
            failures++;
            $display("FAIL single_lane_follow: dout=%b, want 0", data_out);
        end
        data_in = 4'b0100;
        req     = 4'b0000;
        step();
        checks++;
        if (busy !== 1'b0 || data_out !== 1'b0 || sel !== 2'b10 || grant !== 4'b0000) begin
            failures++;
            $display("FAIL single_release: busy=%b dout=%b sel=%b grant=%b, want 0 0 10 0000", busy, data_out, sel, grant);
        end
        step();
        checks++;
        if (busy !== 1'b0 || sel !== 2'b10) begin
            failures++;
            $display("FAIL idle_sel_hold: busy=%b sel=%b, want 0 10", busy, sel);
        end
    endtask

    task automatic test_handover_scan();
        do_reset();
        req = 4'b0010;
        step();
        checks++;
        if (grant !== 4'b0010 || sel !== 2'b01) begin
            failures++;
            $display("FAIL scan_owner1: grant=%b sel=%b, want 0010 01", grant, sel);
        end
        req = 4'b1001;
        step();
        checks++;
        if (grant !== 4'b1000 || sel !== 2'b11 || busy !== 1'b1) begin
            failures++;
            $display("FAIL scan_handover: grant=%b sel=%b busy=%b, want 1000 11 1", grant, sel, busy);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 4'b0100;
        step();
        checks++;
        if (grant !== 4'b0100) begin
            failures++;
            $display("FAIL midreset_pre: grant=%b, want 0100", grant);
        end
        reset = 1'b1;
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || sel !== 2'b00) begin
            failures++;
            $display("FAIL midreset_clear: grant=%b busy=%b sel=%b, want 0000 0 00", grant, busy, sel);
        end
        reset = 1'b0;
        req   = 4'b0110;
        step();
        checks++;
        if (grant !== 4'b0010 || sel !== 2'b01) begin
            failures++;
            $display("FAIL midreset_ptr: grant=%b sel=%b, want 0010 01", grant, sel);
        end
    endtask

    task automatic test_drop_before_grant();
        do_reset();
        req = 4'b0011;
        step();
        req = 4'b0001;
        step();
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL drop_wait_hold: grant=%b, want 0001", grant);
        end
        req = 4'b0000;
        step();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL drop_no_grant: grant=%b busy=%b, want 0000 0", grant, busy);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] exp;
        do_reset();
        req = 4'b0011;
        step();
        for (int r = 0; r < 4; r++) begin
            exp = (r % 2 == 0) ? 4'b0001 : 4'b0010;
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (grant !== exp) begin
                    failures++;
                    $display("FAIL timeout_r%0d_c%0d: grant=%b, want %b", r, c, grant, exp);
                end
                step();
            end
        end
        req = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (grant !== 4'b0001) begin
                failures++;
                $display("FAIL timeout_alone_c%0d: grant=%b, want 0001", c, grant);
            end
            step();
        end
    endtask
`else
    task automatic test_hold_forever();
        do_reset();
        req = 4'b0011;
        step();
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (grant !== 4'b0001 || sel !== 2'b00) begin
                failures++;
                $display("FAIL hold_c%0d: grant=%b sel=%b, want 0001 00", c, grant, sel);
            end
            step();
        end
        req = 4'b0010;
        step();
        checks++;
        if (grant !== 4'b0010) begin
            failures++;
            $display("FAIL hold_waiter_kept: grant=%b, want 0010", grant);
        end
    endtask
`endif

    initial begin
        reset   = 1'b1;
        req     = 4'b0000;
        data_in = 4'b0000;
        test_reset();
        test_fairness();
        test_single_data();
        test_handover_scan();
        test_mid_reset();
        test_drop_before_grant();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hold_forever();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
